// File: rtl/de_pipe_reg_pkg.sv
// Shared pipeline types for the DE/EM/MW registers and the forwarding unit.
// Holds the control bundle, its bubble value and the writeback-hit helper.
package de_pipe_reg_pkg;

    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic       regwrt;
        logic       m2r;
        logic       wrtsrc;
        logic       memwrt;
        logic [3:0] aluop;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{regwrt: 1'b0, m2r: 1'b0, wrtsrc: 1'b0, memwrt: 1'b0, aluop: 4'h0};

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic wb_hit(input logic                 wb_en,
                                    input logic [REG_IDX_W-1:0] wb_rd,
                                    input logic [REG_IDX_W-1:0] src_rs);
        return wb_en && (wb_rd == src_rs) && (src_rs != '0);
    endfunction

endpackage

// File: rtl/de_pipe_reg_sat_counter.sv
// Saturating up-counter: increments while INC is high, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         INC,
    output logic [W-1:0] CNT
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (INC && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign CNT = cnt_q;

endmodule

// File: rtl/de_pipe_reg.sv
// Decode/execute pipeline register with flush, hold, bubble insertion and
// writeback bypass/refresh of the operands it carries.
module de_pipe_reg
    import de_pipe_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 FD_VALID,
    input  logic [XLEN-1:0]      FD_PC,
    input  logic [REG_IDX_W-1:0] FD_RS1,
    input  logic [REG_IDX_W-1:0] FD_RS2,
    input  logic [REG_IDX_W-1:0] FD_RD,
    input  logic [XLEN-1:0]      FD_SRC1,
    input  logic [XLEN-1:0]      FD_SRC2,
    input  logic [XLEN-1:0]      FD_IMM,
    input  logic                 FD_REGWRT,
    input  logic                 FD_M2R,
    input  logic                 FD_WRTSRC,
    input  logic                 FD_MEMWRT,
    input  logic [3:0]           FD_ALUOP,
    input  logic                 HOLD,
    input  logic                 FLUSH,
    input  logic                 MW_REGWRT,
    input  logic [REG_IDX_W-1:0] MW_RD,
    input  logic [XLEN-1:0]      WB_DATA,
    output logic                 DE_VALID,
    output logic [XLEN-1:0]      DE_PC,
    output logic [XLEN-1:0]      DE_SRC1,
    output logic [XLEN-1:0]      DE_SRC2,
    output logic [XLEN-1:0]      DE_IMM,
    output logic [REG_IDX_W-1:0] DE_RS1,
    output logic [REG_IDX_W-1:0] DE_RS2,
    output logic [REG_IDX_W-1:0] DE_RD,
    output logic                 DE_REGWRT,
    output logic                 DE_M2R,
    output logic                 DE_WRTSRC,
    output logic                 DE_MEMWRT,
    output logic [3:0]           DE_ALUOP,
    output logic [CNT_W-1:0]     HOLD_CNT,
    output logic [CNT_W-1:0]     FLUSH_CNT
);

    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      src1_q, src1_d;
    logic [XLEN-1:0]      src2_q, src2_d;
    logic [XLEN-1:0]      imm_q, imm_d;
    logic [REG_IDX_W-1:0] rs1_q, rs1_d;
    logic [REG_IDX_W-1:0] rs2_q, rs2_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    ctrl_t                ctrl_q, ctrl_d;

    // Flush beats hold; an empty FD slot while running also becomes a bubble.
    // Zeroed indices keep the forwarding unit from matching a squashed slot.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (FLUSH || (!HOLD && !FD_VALID)) begin
            valid_d = 1'b0;
            pc_d    = '0;
            src1_d  = '0;
            src2_d  = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = BUBBLE;
        end else if (HOLD) begin
            if (wb_hit(MW_REGWRT, MW_RD, rs1_q)) src1_d = WB_DATA;
            if (wb_hit(MW_REGWRT, MW_RD, rs2_q)) src2_d = WB_DATA;
        end else begin
            valid_d = 1'b1;
            pc_d    = FD_PC;
            imm_d   = FD_IMM;
            rs1_d   = FD_RS1;
            rs2_d   = FD_RS2;
            rd_d    = FD_RD;
            ctrl_d  = '{regwrt: FD_REGWRT, m2r: FD_M2R, wrtsrc: FD_WRTSRC,
                        memwrt: FD_MEMWRT, aluop: FD_ALUOP};
            src1_d  = wb_hit(MW_REGWRT, MW_RD, FD_RS1) ? WB_DATA : FD_SRC1;
            src2_d  = wb_hit(MW_REGWRT, MW_RD, FD_RS2) ? WB_DATA : FD_SRC2;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= BUBBLE;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign DE_VALID  = valid_q;
    assign DE_PC     = pc_q;
    assign DE_SRC1   = src1_q;
    assign DE_SRC2   = src2_q;
    assign DE_IMM    = imm_q;
    assign DE_RS1    = rs1_q;
    assign DE_RS2    = rs2_q;
    assign DE_RD     = rd_q;
    assign DE_REGWRT = ctrl_q.regwrt;
    assign DE_M2R    = ctrl_q.m2r;
    assign DE_WRTSRC = ctrl_q.wrtsrc;
    assign DE_MEMWRT = ctrl_q.memwrt;
    assign DE_ALUOP  = ctrl_q.aluop;

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (HOLD),
        .CNT   (HOLD_CNT)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST_N (RST_N),
        .INC   (FLUSH),
        .CNT   (FLUSH_CNT)
    );

endmodule
